// File: rtl/cvp14_pkg.sv
// Shared CVP14 datapath constants and the vector load FSM state encoding.
package cvp14_pkg;
    localparam int NUM_ELEM = 16;
    localparam int ELEM_W   = 16;
    localparam int ADDR_W   = 16;
    localparam int VEC_W    = NUM_ELEM * ELEM_W;
    localparam int IDX_W    = $clog2(NUM_ELEM);
    localparam int CNT_W    = $clog2(NUM_ELEM) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } vld_state_t;
endpackage

// File: rtl/rd_valid_pipe.sv
// Fixed-depth shift register that delays an issued-request flag by the
// memory latency so the response can be matched to its request.
module rd_valid_pipe #(
    parameter int STAGES = 1
) (
    input  logic Clk,
    input  logic Reset,
    input  logic in_vld,
    output logic out_vld
);
    logic [STAGES-1:0] vld_pipe;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= in_vld;
            for (int i = 1; i < STAGES; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign out_vld = vld_pipe[STAGES-1];
endmodule

// File: rtl/vector_load_unit.sv
// Vector load engine: issues NUM_ELEM sequential word reads from base_addr
// and packs the returned words into a vector buffer, then pulses done.
module vector_load_unit
    import cvp14_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              RD,
    input  logic [ELEM_W-1:0] DataIn,
    output logic [VEC_W-1:0]  DataBuff
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ELEM - 1);

    vld_state_t                     state, state_n;
    logic [ADDR_W-1:0]              base;
    logic [CNT_W-1:0]               issue_cnt, recv_cnt;
    logic [NUM_ELEM-1:0][ELEM_W-1:0] buff;
    logic                           rsp_vld;

    rd_valid_pipe #(.STAGES(MEM_LAT)) u_rd_pipe (
        .Clk    (Clk),
        .Reset  (Reset),
        .in_vld (RD),
        .out_vld(rsp_vld)
    );

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (start) state_n = ISSUE;
            ISSUE: if (issue_cnt == LAST) state_n = DRAIN;
            DRAIN: if (rsp_vld && recv_cnt == LAST) state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // issue_cnt parks on the last index so MemAddr holds through DRAIN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            base      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            buff      <= '0;
        end else begin
            if (state == IDLE && start) begin
                base      <= base_addr;
                issue_cnt <= '0;
                recv_cnt  <= '0;
            end
            if (state == ISSUE && issue_cnt != LAST)
                issue_cnt <= issue_cnt + 1'b1;
            if (rsp_vld) begin
                buff[recv_cnt[IDX_W-1:0]] <= DataIn;
                recv_cnt                  <= recv_cnt + 1'b1;
            end
        end
    end

    assign RD       = (state == ISSUE);
    assign MemAddr  = base + ADDR_W'(issue_cnt);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign DataBuff = buff;
endmodule

// File: tb/tb_vector_load_unit.sv
// Random-stimulus bench for vector_load_unit at MEM_LAT=1 and MEM_LAT=3.
module tb_vector_load_unit;
    logic        Clk = 1'b0;
    logic        rst [2];
    logic        st  [2];
    logic [15:0] ba  [2];
    logic        bsy [2];
    logic        dn  [2];
    logic [15:0] addr[2];
    logic        rd  [2];
    logic [15:0] din [2];
    logic [255:0] vbuf[2];

    logic [15:0]  key [2];
    logic [15:0]  mp  [2][4];
    logic [255:0] exp_vec[2];
    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    vector_load_unit #(.MEM_LAT(1)) u_dut1 (
        .Clk(Clk), .Reset(rst[0]), .start(st[0]), .base_addr(ba[0]), .busy(bsy[0]),
        .done(dn[0]), .MemAddr(addr[0]), .RD(rd[0]), .DataIn(din[0]), .DataBuff(vbuf[0]));
    vector_load_unit #(.MEM_LAT(3)) u_dut3 (
        .Clk(Clk), .Reset(rst[1]), .start(st[1]), .base_addr(ba[1]), .busy(bsy[1]),
        .done(dn[1]), .MemAddr(addr[1]), .RD(rd[1]), .DataIn(din[1]), .DataBuff(vbuf[1]));

    // memory: data for a read sampled at edge Ek appears after edge Ek+lat-1
    always @(posedge Clk)
        for (int d = 0; d < 2; d++) begin
            for (int j = 3; j > 0; j--) mp[d][j] <= mp[d][j-1];
            mp[d][0] <= rd[d] ? (addr[d] ^ key[d]) : 16'hDEAD;
        end
    assign din[0] = mp[0][0];
    assign din[1] = mp[1][2];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] model_vec(input logic [15:0] base, input logic [15:0] k);
        logic [255:0] v;
        for (int i = 0; i < 16; i++) v[i*16 +: 16] = (base + 16'(i)) ^ k;
        return v;
    endfunction

    // one load on DUT d; ign_at/rst_at = cycle to inject a busy start / reset (-1 none)
    task automatic do_load(input int d, input logic [15:0] base, input int ign_at,
                           input int rst_at, input int extra);
        int lat, kend, n, done_n, done_k, addr_bad, busy_bad;
        logic [255:0] prev;
        lat = (d == 0) ? 1 : 3;
        kend = 17 + lat + extra;
        prev = exp_vec[d];
        n = 0; done_n = 0; done_k = -1; addr_bad = 0; busy_bad = 0;
        st[d] = 1'b1; ba[d] = base;
        for (int k = 1; k <= kend; k++) begin
            @(negedge Clk);
            if (k == 1) begin
                st[d] = 1'b0; ba[d] = 16'($urandom);
                chk($sformatf("d%0d hold_old", d), vbuf[d], prev);
            end
            if (rd[d]) begin
                if (addr[d] !== base + 16'(n)) addr_bad++;
                n++;
            end
            if (dn[d]) begin done_n++; done_k = k; end
            if (rst_at < 0 && bsy[d] !== (k <= 17 + lat)) busy_bad++;
            if (k == ign_at) begin st[d] = 1'b1; ba[d] = 16'h1234; end
            if (k == ign_at + 1) st[d] = 1'b0;
            if (k == rst_at + 1) begin
                chk($sformatf("d%0d rst_rd", d), {255'd0, rd[d]}, 256'd0);
                chk($sformatf("d%0d rst_busy", d), {255'd0, bsy[d]}, 256'd0);
                chk($sformatf("d%0d rst_buf", d), vbuf[d], 256'd0);
                rst[d] = 1'b0;
            end
            if (k == rst_at) rst[d] = 1'b1;
        end
        if (rst_at >= 0) begin
            chk($sformatf("d%0d rst_nodone", d), 256'(done_n), 256'd0);
            exp_vec[d] = '0;
        end else begin
            exp_vec[d] = model_vec(base, key[d]);
            chk($sformatf("d%0d rd_cnt", d), 256'(n), 256'd16);
            chk($sformatf("d%0d addr_bad", d), 256'(addr_bad), 256'd0);
            chk($sformatf("d%0d done_cnt", d), 256'(done_n), 256'd1);
            chk($sformatf("d%0d done_cyc", d), 256'(done_k), 256'(17 + lat));
            chk($sformatf("d%0d busy_bad", d), 256'(busy_bad), 256'd0);
            chk($sformatf("d%0d buff", d), vbuf[d], exp_vec[d]);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; st[d] = 1'b0; ba[d] = 16'h0; key[d] = 16'hA5A5; exp_vec[d] = '0;
        end
        repeat (3) @(negedge Clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d reset_out", d),
                {220'd0, bsy[d], dn[d], rd[d], addr[d], 1'b0}, 256'd0);
            chk($sformatf("d%0d reset_buf", d), vbuf[d], 256'd0);
            rst[d] = 1'b0;
        end
        @(negedge Clk);

        for (int d = 0; d < 2; d++) begin
            key[d] = 16'hA5A5;
            do_load(d, 16'h00F8, -1, -1, 4);
            chk($sformatf("d%0d elem0", d), 256'(vbuf[d][15:0]), 256'h A55D);
            chk($sformatf("d%0d elem15", d), 256'(vbuf[d][255:240]), 256'h A4A2);
            do_load(d, 16'hFFF8, -1, -1, 4);           // address wrap
            do_load(d, 16'h0300, 5, -1, 4);            // start while busy ignored
            do_load(d, 16'h0500, -1, 8, 2);            // reset mid-operation
            do_load(d, 16'h0040, -1, -1, 1);
            key[d] = 16'($urandom);
            do_load(d, 16'h0200, -1, -1, 4);           // back-to-back start
            for (int r = 0; r < 3; r++) begin
                key[d] = 16'($urandom);
                do_load(d, 16'($urandom), -1, -1, 1 + int'($urandom_range(0, 3)));
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
